rf_scoreboard: RTL
==================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, hardwires register 0 to zero when 1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_rd_addr1  input  ADDR_W  read port 1 address.
REQ-007 o_rd_data1  output  DATA_W  read port 1 data, combinational.
REQ-008 o_rd_busy1  output  1  register at i_rd_addr1 has a pending write.
REQ-009 i_rd_addr2, o_rd_data2, o_rd_busy2: read port 2, identical in width and meaning to port 1.
REQ-010 i_wr_addr  input  ADDR_W  write-back address.
REQ-011 i_wr_data  input  DATA_W  write-back data.
REQ-012 i_wr_en  input  1  write-back strobe.
REQ-013 i_rsv_addr  input  ADDR_W  destination register reserved by an issuing instruction.
REQ-014 i_rsv_en  input  1  reservation strobe.
REQ-015 o_busy_cnt  output  ADDR_W+1  number of registers currently busy, registered.

Function
REQ-016 Storage: 2**ADDR_W data words plus one busy bit per register.
REQ-017 Reads: asynchronous, zero latency, both ports independent; same address on both ports is legal.
REQ-018 Write: i_wr_en=1 stores i_wr_data at i_wr_addr on the next rising edge and clears that register's busy bit.
REQ-019 Reserve: i_rsv_en=1 sets the busy bit of i_rsv_addr on the next rising edge.
REQ-020 Reserve of an already-busy register: bit stays 1, o_busy_cnt unchanged.
REQ-021 Write to a non-busy register: data stored, o_busy_cnt unchanged.
REQ-022 Same-cycle write and reserve to the same address: data stored, busy ends at 1, o_busy_cnt +1 if previously not busy, else unchanged.
REQ-023 Same-cycle write and reserve to different addresses: both take effect, o_busy_cnt = old - (write cleared a busy bit) + (reserve set a clear bit).
REQ-024 o_busy_cnt never wraps; its maximum is 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG=1).
REQ-025 ZERO_REG=1: reads of address 0 return 0 with busy 0; writes and reserves to address 0 are ignored.
REQ-026 ZERO_REG=0: address 0 behaves as any other register.
REQ-027 Read outputs reflect registered state except as modified by the bypass feature (REQ-031).

Reset
REQ-028 While rst=1: all data words 0, all busy bits 0, o_busy_cnt 0, independent of clk.
REQ-029 Write and reserve strobes are ignored while rst=1; reset mid-operation discards all pending reservations.
REQ-030 The first edge after rst deasserts operates normally.

Configuration
REQ-031 With RF_SCOREBOARD_BYPASS_EN defined: a read port whose address equals i_wr_addr while i_wr_en=1 (excluding address 0 when ZERO_REG=1) outputs i_wr_data and busy 0 in the same cycle.
REQ-032 Without RF_SCOREBOARD_BYPASS_EN: read ports show only registered data and busy bits; a written value is visible from the cycle after the write edge.

Verification
REQ-033 Reset, read all addresses -> data 0, busy 0, o_busy_cnt 0.
REQ-034 Reserve r5, next cycle write r5=0xDEADBEEF -> busy1(r5)=1 and cnt=1 after the first edge; data 0xDEADBEEF, busy 0, cnt 0 after the second.
REQ-035 Same cycle: write r7=0x11 and reserve r7, with r7 idle -> r7 data 0x11, busy 1, cnt 1.
REQ-036 ZERO_REG=1: write r0=0xFFFFFFFF and reserve r0 -> r0 reads 0, busy 0, cnt 0.
REQ-037 Bypass defined: i_wr_en=1, r3=0x55, i_rd_addr1=3 -> o_rd_data1=0x55 in the same cycle; undefined: old value until after the edge.
REQ-038 Reserve r1..r31 over 31 cycles, then assert rst mid-sequence -> cnt reaches 31, then immediately returns to 0 with all busy bits 0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- register file with a per-register busy (scoreboard) bit.
//
// Purpose:
//   Holds 2**ADDR_W data words. Each word has a busy bit. Reserving a
//   register sets its busy bit. Writing it back stores the data and clears
//   the bit. Two independent combinational read ports return data and busy
//   for any address. o_busy_cnt is a registered count of the busy registers.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - register address width; depth is 2**ADDR_W
//   ZERO_REG - 1: register 0 always reads 0 / not busy, and writes and
//              reserves to it are ignored
//
// Ports:
//   clk                                   clock, rising edge
//   rst                                   asynchronous active-high reset
//   i_rd_addr1 / o_rd_data1 / o_rd_busy1  read port 1
//   i_rd_addr2 / o_rd_data2 / o_rd_busy2  read port 2
//   i_wr_addr / i_wr_data / i_wr_en       write-back port
//   i_rsv_addr / i_rsv_en                 reservation port
//   o_busy_cnt                            number of busy registers (registered)
//
// Optional feature (define the macro to enable):
//   RF_SCOREBOARD_BYPASS_EN - when a read address matches an active write,
//   the read port shows the write data and busy 0 in the same cycle.

module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic              o_rd_busy1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_rd_busy2,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic              i_rsv_en,
  output logic [ADDR_W:0]   o_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  logic wr_valid;
  logic rsv_valid;
  logic cnt_dec;
  logic cnt_inc;

  // Strobes aimed at the hardwired zero register are dropped here, so the
  // storage and the counter never see them.
  assign wr_valid  = i_wr_en  && !((ZERO_REG != 0) && (i_wr_addr  == '0));
  assign rsv_valid = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == '0));

  // Next busy vector: a write clears first, and a reserve to the same
  // address then wins, so the bit ends at 1.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[i_wr_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[i_rsv_addr] = 1'b1;
    end
  end

  // Incremental count. A write only decrements when it really clears a busy
  // bit that is not set again by a same-address reserve in the same cycle.
  // A reserve only increments when it sets a bit that was clear.
  assign cnt_dec = wr_valid && busy_q[i_wr_addr] &&
                   !(rsv_valid && (i_rsv_addr == i_wr_addr));
  assign cnt_inc = rsv_valid && !busy_q[i_rsv_addr];
  assign cnt_d   = cnt_q - CW'(cnt_dec) + CW'(cnt_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_busy_cnt = cnt_q;

  // One data word and one busy flop per register. Every flop needs the
  // asynchronous clear, so the storage is built from flops, not RAM.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] word_q;
      logic              bit_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= '0;
          bit_q  <= 1'b0;
        end else begin
          if (wr_valid && (i_wr_addr == ADDR_W'(gi))) begin
            word_q <= i_wr_data;
          end
          bit_q <= busy_d[gi];
        end
      end

      assign mem_q[gi]  = word_q;
      assign busy_q[gi] = bit_q;
    end
  endgenerate

  // Read ports
  always_comb begin
    o_rd_data1 = mem_q[i_rd_addr1];
    o_rd_busy1 = busy_q[i_rd_addr1];
    if ((ZERO_REG != 0) && (i_rd_addr1 == '0)) begin
      o_rd_data1 = '0;
      o_rd_busy1 = 1'b0;
    end
`ifdef RF_SCOREBOARD_BYPASS_EN
    // wr_valid already excludes the zero register.
    if (wr_valid && (i_rd_addr1 == i_wr_addr)) begin
      o_rd_data1 = i_wr_data;
      o_rd_busy1 = 1'b0;
    end
`endif
  end

  always_comb begin
    o_rd_data2 = mem_q[i_rd_addr2];
    o_rd_busy2 = busy_q[i_rd_addr2];
    if ((ZERO_REG != 0) && (i_rd_addr2 == '0)) begin
      o_rd_data2 = '0;
      o_rd_busy2 = 1'b0;
    end
`ifdef RF_SCOREBOARD_BYPASS_EN
    if (wr_valid && (i_rd_addr2 == i_wr_addr)) begin
      o_rd_data2 = i_wr_data;
      o_rd_busy2 = 1'b0;
    end
`endif
  end

endmodule
